// File: rtl/clock_pkg.sv
// Shared constants, BCD pair type and binary-to-BCD helper for the time-of-day counter.
package clock_pkg;

    localparam int unsigned SEC_MAX_DEF  = 59;
    localparam int unsigned MIN_MAX_DEF  = 59;
    localparam int unsigned HOUR_MAX_DEF = 23;

    // [7:4] tens digit, [3:0] ones digit
    typedef logic [7:0] bcd_pair_t;

    // Valid for inputs 0..59; tens digit never exceeds 5.
    function automatic bcd_pair_t bin_to_bcd(input logic [5:0] bin);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = bin / 6'd10;
        ones = bin - (tens * 6'd10);
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter with parallel load and a wrap flag for carry chaining.
module bcd_pair_counter
    import clock_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      inc,
    input  logic      load,
    input  bcd_pair_t ld_val,
    output bcd_pair_t val,
    output logic      wrap
);

    localparam bcd_pair_t MAX_BCD = bin_to_bcd(6'(MAX));

    bcd_pair_t r_val;
    bcd_pair_t w_next;

    always_comb begin
        w_next = r_val;
        if (load) begin
            w_next = ld_val;
        end else if (inc) begin
            // field wrap is decided on the whole pair, digit carry on the ones
            if (r_val == MAX_BCD) begin
                w_next = '0;
            end else if (r_val[3:0] == 4'd9) begin
                w_next = {r_val[7:4] + 4'd1, 4'd0};
            end else begin
                w_next = {r_val[7:4], r_val[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val <= '0;
        end else begin
            r_val <= w_next;
        end
    end

    assign val  = r_val;
    assign wrap = inc && (r_val == MAX_BCD);

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter driven by a 1 Hz tick, with load, minute/hour adjust and day rollover.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter int unsigned HOUR_MAX = HOUR_MAX_DEF,
    parameter int unsigned SEC_MAX  = SEC_MAX_DEF,
    parameter int unsigned MIN_MAX  = MIN_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       run,
    input  logic       load,
    input  logic [4:0] ld_hh,
    input  logic [5:0] ld_mm,
    input  logic [5:0] ld_ss,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       day_roll,
    output logic       load_err
);

    logic r_pend_min;
    logic r_pend_hr;
    logic r_day_roll;
    logic r_load_err;

    logic w_load_ok;
    logic w_load_acc;
    logic w_tick_en;
    logic w_count;
    logic w_blocked;
    logic w_adj_min;
    logic w_adj_hr;
    logic w_sec_inc;
    logic w_min_inc;
    logic w_hr_inc;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hr_wrap;

    bcd_pair_t w_hh;
    bcd_pair_t w_mm;
    bcd_pair_t w_ss;

    assign w_load_ok  = ({27'd0, ld_hh} <= HOUR_MAX) &&
                        ({26'd0, ld_mm} <= MIN_MAX)  &&
                        ({26'd0, ld_ss} <= SEC_MAX);
    assign w_load_acc = load && w_load_ok;
    assign w_tick_en  = run && tick;
    assign w_count    = w_tick_en && !load;

    // Any load (accepted or not) or counting tick defers adjusts to a later idle cycle.
    assign w_blocked  = load || w_tick_en;
    assign w_adj_min  = !w_blocked && (inc_min || r_pend_min);
    assign w_adj_hr   = !w_blocked && (inc_hr  || r_pend_hr);

    assign w_sec_inc  = w_count;
    assign w_min_inc  = (w_count && w_sec_wrap) || w_adj_min;
    assign w_hr_inc   = (w_count && w_min_wrap) || w_adj_hr;

    bcd_pair_counter #(.MAX(SEC_MAX)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_sec_inc),
        .load   (w_load_acc),
        .ld_val (bin_to_bcd(ld_ss)),
        .val    (w_ss),
        .wrap   (w_sec_wrap)
    );

    bcd_pair_counter #(.MAX(MIN_MAX)) u_min (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_min_inc),
        .load   (w_load_acc),
        .ld_val (bin_to_bcd(ld_mm)),
        .val    (w_mm),
        .wrap   (w_min_wrap)
    );

    bcd_pair_counter #(.MAX(HOUR_MAX)) u_hr (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_hr_inc),
        .load   (w_load_acc),
        .ld_val (bin_to_bcd({1'b0, ld_hh})),
        .val    (w_hh),
        .wrap   (w_hr_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_min <= 1'b0;
            r_pend_hr  <= 1'b0;
            r_day_roll <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            if (w_blocked) begin
                r_pend_min <= r_pend_min || inc_min;
                r_pend_hr  <= r_pend_hr  || inc_hr;
            end else begin
                r_pend_min <= 1'b0;
                r_pend_hr  <= 1'b0;
            end
            r_day_roll <= w_count && w_hr_wrap;
            r_load_err <= load && !w_load_ok;
        end
    end

    assign hh_bcd   = w_hh;
    assign mm_bcd   = w_mm;
    assign ss_bcd   = w_ss;
    assign day_roll = r_day_roll;
    assign load_err = r_load_err;

endmodule
